dm_ctrl: RTL

M-stage memory access controller between the pipeline's M stage and a variable-latency data memory bus. Accepts one load/store per request, generates byte enables and lane-replicated write data, and formats load data (byte/half/word, signed/unsigned). Stalls the pipeline until the bus acknowledges or a timeout fires. Replaces the single-cycle dm instance so that lb/lbu/lh/lhu/sb/sh/sw and slow memories are supported.

---
 rtl/dm_ctrl_pkg.sv | 50 +++++
 rtl/dm_ctrl_if.sv | 35 +++
 rtl/dm_ctrl_ld_fmt.sv | 23 ++
 rtl/dm_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared size/state codes and lane helpers for the M-stage memory controller
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_R = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    is_illegal = 1'b0;
            SZ_H:    is_illegal = off[0];
            SZ_W:    is_illegal = |off;
            default: is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    lane_wdata = {4{wdata[7:0]}};
            SZ_H:    lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// rtl/dm_ctrl_if.sv - pipeline request and data-memory bus signals of the M-stage controller
interface dm_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        align_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output stall, rdata, rdata_valid, align_err, bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  stall, rdata, rdata_valid, align_err, bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/dm_ctrl_ld_fmt.sv
// rtl/dm_ctrl_ld_fmt.sv - selects the addressed byte/half lane of a bus word and extends it to 32 bits
module ld_fmt
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{off_i, 3'b000} +: 8];
        half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_B:    data_o = {{24{sgn_i & byte_lane[7]}}, byte_lane};
            SZ_H:    data_o = {{16{sgn_i & half_lane[15]}}, half_lane};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - M-stage load/store controller: latches one request, drives the bus until ack or
// timeout, then presents formatted load data or a bus error for one cycle while the pipeline advances.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst,
    dm_ctrl_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    req_t                 req_q, req_d;
    logic                 abort_q, abort_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 illegal;
    logic [31:0]          fmt_data;

    ld_fmt u_ld_fmt (
        .word_i (bus.mem_rdata),
        .off_i  (req_q.addr[1:0]),
        .size_i (req_q.size),
        .sgn_i  (req_q.sgn),
        .data_o (fmt_data)
    );

    assign illegal = is_illegal(bus.req_size, bus.req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            abort_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_d           = req_q;
        abort_d         = abort_q;
        rdata_d         = rdata_q;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_be      = '0;
        bus.mem_wdata   = '0;
        bus.rdata_valid = 1'b0;
        bus.bus_err     = 1'b0;
        bus.rdata       = rdata_q;
        // The pipeline is released in DONE so it advances exactly once per completed access.
        bus.stall       = bus.req_valid && !illegal && (state_q != S_DONE);
        bus.align_err   = bus.req_valid && (state_q == S_IDLE) && illegal;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !illegal) begin
                    req_d.write = bus.req_write;
                    req_d.size  = bus.req_size;
                    req_d.sgn   = bus.req_signed;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    cnt_d       = '0;
                    abort_d     = 1'b0;
                    rdata_d     = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = req_q.write;
                bus.mem_addr  = {req_q.addr[31:2], 2'b00};
                bus.mem_be    = byte_en(req_q.size, req_q.addr[1:0]);
                bus.mem_wdata = lane_wdata(req_q.size, req_q.wdata);
                cnt_d         = cnt_q + CNT_WIDTH'(1);
                // An ack on the final counted cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    if (!req_q.write) begin
                        rdata_d = fmt_data;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.rdata_valid = !req_q.write && !abort_q;
                bus.bus_err     = abort_q;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
